// File: rtl/test_template.sv
// Self-checking test sequencer for an incrementer DUT (resp = stim + 1).
// Optional build macro TT_STOP_ON_ERROR_EN: end the run at the first error.
module test_template #(
   parameter int DATA_W      = 8,
   parameter int NUM_VECTORS = 16,
   parameter int TIMEOUT     = 15,
   parameter int CNT_W       = 16
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start_i,
   input  logic [DATA_W-1:0] seed_i,
   output logic              stim_valid_o,
   output logic [DATA_W-1:0] stim_data_o,
   input  logic              stim_ready_i,
   input  logic              resp_valid_i,
   input  logic [DATA_W-1:0] resp_data_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              pass_o,
   output logic [CNT_W-1:0]  error_count_o,
   output logic [CNT_W-1:0]  warning_count_o
);

   localparam int IDX_W = $clog2(NUM_VECTORS + 1);
   localparam int TMR_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      WAIT,
      DONE
   } state_t;

   state_t            state;
   logic [DATA_W-1:0] expected;
   logic [IDX_W-1:0]  index;
   logic [TMR_W-1:0]  timer;

   logic last_vector;
   logic timed_out;
   logic resp_err;
   logic stop_now;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign last_vector = (index == IDX_W'(NUM_VECTORS - 1));
   assign timed_out   = (timer == TMR_W'(TIMEOUT - 1));
   // A WAIT-cycle event is an error when no response arrived (timeout) or the data is wrong.
   assign resp_err    = !resp_valid_i || (resp_data_i != expected);

`ifdef TT_STOP_ON_ERROR_EN
   assign stop_now = resp_err;
`else
   assign stop_now = 1'b0;
`endif

   assign pass_o = done_o && (error_count_o == '0);

   // NOTE: every register here is updated with <= so all branches see the
   // pre-edge values; blocking assignments would create order-dependent state.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state           <= IDLE;
         stim_valid_o    <= 1'b0;
         stim_data_o     <= '0;
         busy_o          <= 1'b0;
         done_o          <= 1'b0;
         error_count_o   <= '0;
         warning_count_o <= '0;
         expected        <= '0;
         index           <= '0;
         timer           <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start_i) begin
                  state           <= SEND;
                  stim_valid_o    <= 1'b1;
                  stim_data_o     <= seed_i;
                  busy_o          <= 1'b1;
                  done_o          <= 1'b0;
                  error_count_o   <= '0;
                  warning_count_o <= '0;
                  index           <= '0;
               end else if (resp_valid_i) begin
                  warning_count_o <= sat_inc(warning_count_o);
               end
            end

            SEND: begin
               if (resp_valid_i) begin
                  warning_count_o <= sat_inc(warning_count_o);
               end
               if (stim_ready_i) begin
                  state        <= WAIT;
                  stim_valid_o <= 1'b0;
                  expected     <= stim_data_o + 1'b1;
                  timer        <= '0;
               end
            end

            WAIT: begin
               // A response on the timeout cycle wins; the timeout is not counted.
               if (resp_valid_i || timed_out) begin
                  index       <= index + 1'b1;
                  stim_data_o <= stim_data_o + 1'b1;
                  if (resp_err) begin
                     error_count_o <= sat_inc(error_count_o);
                  end
                  if (!resp_valid_i) begin
                     warning_count_o <= sat_inc(warning_count_o);
                  end
                  if (last_vector || stop_now) begin
                     state  <= DONE;
                     busy_o <= 1'b0;
                     done_o <= 1'b1;
                  end else begin
                     state        <= SEND;
                     stim_valid_o <= 1'b1;
                  end
               end else begin
                  timer <= timer + 1'b1;
               end
            end

            default: begin
               state        <= IDLE;
               stim_valid_o <= 1'b0;
               busy_o       <= 1'b0;
               done_o       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_test_template.sv
// Directed bench for test_template: a scripted incrementer DUT with fault injection.
module tb_test_template;

   logic        clk;
   logic        resetn;
   logic        start_i;
   logic [7:0]  seed_i;
   logic        stim_valid_o;
   logic [7:0]  stim_data_o;
   logic        stim_ready_i;
   logic        resp_valid_i;
   logic [7:0]  resp_data_i;
   logic        busy_o;
   logic        done_o;
   logic        pass_o;
   logic [15:0] error_count_o;
   logic [15:0] warning_count_o;

   int checks;
   int failures;

   localparam int MODE_GOOD = 0;
   localparam int MODE_BAD  = 1;
   localparam int MODE_DROP = 2;

   test_template dut (
      .clk             (clk),
      .resetn          (resetn),
      .start_i         (start_i),
      .seed_i          (seed_i),
      .stim_valid_o    (stim_valid_o),
      .stim_data_o     (stim_data_o),
      .stim_ready_i    (stim_ready_i),
      .resp_valid_i    (resp_valid_i),
      .resp_data_i     (resp_data_i),
      .busy_o          (busy_o),
      .done_o          (done_o),
      .pass_o          (pass_o),
      .error_count_o   (error_count_o),
      .warning_count_o (warning_count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got=running exp=finished");
      $fatal(1, "watchdog expired");
   end

   // Serves one vector: checks the stimulus, holds ready low one cycle to test stability,
   // then answers with stim+1 (GOOD), stim+2 (BAD) or never (DROP).
   task automatic serve_vector(input logic [7:0] exp_stim, input int mode);
      int n;
      logic [7:0] resp;
      n = 0;
      while (stim_valid_o !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (stim_valid_o !== 1'b1) begin
         $display("FAIL stim_valid_wait got=%b exp=1", stim_valid_o);
         failures++;
         return;
      end
      checks++;
      if (stim_data_o !== exp_stim) begin
         $display("FAIL stim_data got=%h exp=%h", stim_data_o, exp_stim);
         failures++;
      end
      @(negedge clk);
      checks++;
      if (stim_valid_o !== 1'b1 || stim_data_o !== exp_stim) begin
         $display("FAIL stim_hold got=%b/%h exp=1/%h", stim_valid_o, stim_data_o, exp_stim);
         failures++;
      end
      stim_ready_i = 1'b1;
      @(negedge clk);
      stim_ready_i = 1'b0;
      checks++;
      if (stim_valid_o !== 1'b0 || busy_o !== 1'b1) begin
         $display("FAIL wait_state valid/busy got=%b/%b exp=0/1", stim_valid_o, busy_o);
         failures++;
      end
      if (mode == MODE_DROP) begin
         n = 0;
         while (stim_valid_o !== 1'b1 && done_o !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
         end
         checks++;
         if (n != 15) begin
            $display("FAIL timeout_cycles got=%0d exp=15", n);
            failures++;
         end
      end else begin
         @(negedge clk);
         resp = (mode == MODE_BAD) ? exp_stim + 8'd2 : exp_stim + 8'd1;
         resp_valid_i = 1'b1;
         resp_data_i  = resp;
         @(negedge clk);
         resp_valid_i = 1'b0;
      end
   endtask

   task automatic start_run(input logic [7:0] seed);
      start_i = 1'b1;
      seed_i  = seed;
      @(negedge clk);
      start_i = 1'b0;
      checks++;
      if (stim_valid_o !== 1'b1 || busy_o !== 1'b1 || done_o !== 1'b0 ||
          error_count_o !== 16'd0 || warning_count_o !== 16'd0) begin
         $display("FAIL start_state valid/busy/done/err/warn got=%b/%b/%b/%0d/%0d exp=1/1/0/0/0",
                  stim_valid_o, busy_o, done_o, error_count_o, warning_count_o);
         failures++;
      end
   endtask

   task automatic check_end(input string name, input int exp_err, input int exp_warn);
      logic exp_pass;
      exp_pass = (exp_err == 0);
      checks++;
      if (done_o !== 1'b1 || busy_o !== 1'b0 || pass_o !== exp_pass) begin
         $display("FAIL %s_end done/busy/pass got=%b/%b/%b exp=1/0/%b",
                  name, done_o, busy_o, pass_o, exp_pass);
         failures++;
      end
      checks++;
      if (error_count_o !== 16'(exp_err) || warning_count_o !== 16'(exp_warn)) begin
         $display("FAIL %s_counts err/warn got=%0d/%0d exp=%0d/%0d",
                  name, error_count_o, warning_count_o, exp_err, exp_warn);
         failures++;
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      checks++;
      if (stim_valid_o !== 1'b0 || stim_data_o !== 8'h00 || busy_o !== 1'b0 ||
          done_o !== 1'b0 || pass_o !== 1'b0 || error_count_o !== 16'd0 ||
          warning_count_o !== 16'd0) begin
         $display("FAIL reset_state valid/data/busy/done/pass/err/warn got=%b/%h/%b/%b/%b/%0d/%0d exp=all zero",
                  stim_valid_o, stim_data_o, busy_o, done_o, pass_o, error_count_o, warning_count_o);
         failures++;
      end
   endtask

   task automatic test_unsolicited_idle();
      resp_valid_i = 1'b1;
      resp_data_i  = 8'hAA;
      @(negedge clk);
      resp_valid_i = 1'b0;
      checks++;
      if (warning_count_o !== 16'd1 || busy_o !== 1'b0 || done_o !== 1'b0) begin
         $display("FAIL unsolicited_idle warn/busy/done got=%0d/%b/%b exp=1/0/0",
                  warning_count_o, busy_o, done_o);
         failures++;
      end
   endtask

   task automatic test_ideal_run(input string name, input logic [7:0] seed);
      start_run(seed);
      for (int i = 0; i < 16; i++) serve_vector(seed + 8'(i), MODE_GOOD);
      check_end(name, 0, 0);
   endtask

   task automatic test_start_during_send();
      start_run(8'h30);
      start_i = 1'b1;
      seed_i  = 8'h99;
      @(negedge clk);
      start_i = 1'b0;
      checks++;
      if (stim_valid_o !== 1'b1 || stim_data_o !== 8'h30) begin
         $display("FAIL start_ignored valid/data got=%b/%h exp=1/30", stim_valid_o, stim_data_o);
         failures++;
      end
      for (int i = 0; i < 16; i++) serve_vector(8'h30 + 8'(i), MODE_GOOD);
      check_end("start_in_send", 0, 0);
   endtask

   task automatic test_error_vector();
      start_run(8'h20);
      for (int i = 0; i < 16; i++) begin
         serve_vector(8'h20 + 8'(i), (i == 3) ? MODE_BAD : MODE_GOOD);
`ifdef TT_STOP_ON_ERROR_EN
         if (i == 3) break;
`endif
      end
      check_end("error_v3", 1, 0);
   endtask

   task automatic test_timeout();
      start_run(8'h50);
      serve_vector(8'h50, MODE_DROP);
      checks++;
      if (error_count_o !== 16'd1 || warning_count_o !== 16'd1) begin
         $display("FAIL timeout_counts err/warn got=%0d/%0d exp=1/1", error_count_o, warning_count_o);
         failures++;
      end
`ifndef TT_STOP_ON_ERROR_EN
      for (int i = 1; i < 16; i++) serve_vector(8'h50 + 8'(i), MODE_GOOD);
`endif
      check_end("timeout", 1, 1);
   endtask

   task automatic test_reset_mid_wait();
      start_run(8'h40);
      resp_valid_i = 1'b1;
      resp_data_i  = 8'h41;
      @(negedge clk);
      resp_valid_i = 1'b0;
      checks++;
      if (warning_count_o !== 16'd1 || stim_data_o !== 8'h40) begin
         $display("FAIL unsolicited_send warn/data got=%0d/%h exp=1/40", warning_count_o, stim_data_o);
         failures++;
      end
      stim_ready_i = 1'b1;
      @(negedge clk);
      stim_ready_i = 1'b0;
      @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      checks++;
      if (busy_o !== 1'b0 || done_o !== 1'b0 || stim_valid_o !== 1'b0 ||
          error_count_o !== 16'd0 || warning_count_o !== 16'd0) begin
         $display("FAIL reset_mid_wait busy/done/valid/err/warn got=%b/%b/%b/%0d/%0d exp=0/0/0/0/0",
                  busy_o, done_o, stim_valid_o, error_count_o, warning_count_o);
         failures++;
      end
      repeat (3) @(negedge clk);
      checks++;
      if (stim_valid_o !== 1'b0 || busy_o !== 1'b0) begin
         $display("FAIL idle_after_reset valid/busy got=%b/%b exp=0/0", stim_valid_o, busy_o);
         failures++;
      end
   endtask

   initial begin
      checks       = 0;
      failures     = 0;
      resetn       = 1'b0;
      start_i      = 1'b0;
      seed_i       = 8'h00;
      stim_ready_i = 1'b0;
      resp_valid_i = 1'b0;
      resp_data_i  = 8'h00;
      @(negedge clk);

      test_reset();
      test_unsolicited_idle();
      test_ideal_run("seed10", 8'h10);
      test_ideal_run("wrap_fe", 8'hFE);
      test_start_during_send();
      test_error_vector();
      test_timeout();
      test_reset_mid_wait();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
